// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, the NZP condition-code type and the
// condition-code encoder used by the register file and its cc_unit.
//   DEFAULT_WIDTH / DEFAULT_NREGS : default datapath geometry
//   CC_MAX_W                      : widest data word cc_encode accepts
//   nzp_t                         : packed {n,z,p} condition codes
//   NZP_RESET                     : condition codes after reset (Z set)
//   cc_encode(data, msb)          : one-hot NZP of a zero-extended word
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_NREGS = 8;
  localparam int CC_MAX_W      = 64;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam nzp_t NZP_RESET = 3'b010;

  // The caller zero-extends its word to CC_MAX_W and passes the index of its
  // own sign bit, so one function serves every WIDTH up to CC_MAX_W.
  // The result is always exactly one-hot.
  function automatic nzp_t cc_encode(input logic [CC_MAX_W-1:0] data,
                                     input logic [5:0]          msb);
    nzp_t cc;
    cc = '0;
    if (data[msb])       cc.n = 1'b1;
    else if (data == '0) cc.z = 1'b1;
    else                 cc.p = 1'b1;
    return cc;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_cc_unit.sv
// cc_unit: NZP condition-code register and registered branch-enable flag.
//   Clk, Reset   : clock, synchronous active-low reset
//   LD_CC        : load NZP from the encoding of Data
//   LD_BEN       : load BEN <= |(CondIR & NZP), using NZP before this edge
//   CondIR [2:0] : branch condition mask {n,z,p}
//   Data         : word whose sign/zero state sets NZP
//   NZP [2:0]    : registered condition codes {N,Z,P}
//   BEN          : registered branch enable
module cc_unit
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic [2:0]       CondIR,
  input  logic [WIDTH-1:0] Data,
  output logic [2:0]       NZP,
  output logic             BEN
);

  nzp_t nzp_q, nzp_d;
  logic ben_q, ben_d;

  assign nzp_d = cc_encode(CC_MAX_W'(Data), 6'(WIDTH - 1));
  // Uses the registered NZP, so a coincident LD_CC does not affect BEN.
  assign ben_d = |(CondIR & nzp_q);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      nzp_q <= NZP_RESET;
      ben_q <= 1'b0;
    end else begin
      if (LD_CC)  nzp_q <= nzp_d;
      if (LD_BEN) ben_q <= ben_d;
    end
  end

  assign NZP = nzp_q;
  assign BEN = ben_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREGS x WIDTH register file with two combinational
// read ports, one write port, optional write-to-read bypass, a per-register
// busy scoreboard for in-flight writebacks, and the NZP/BEN unit.
//   Clk, Reset                 : clock, synchronous active-low reset
//   WrEn, WrAddr, WrData       : writeback port; a write also clears busy
//   Rsv, RsvAddr               : decode reservation; sets busy
//   Rd1Addr/Rd1Data, Busy1     : read port 1 and its busy flag
//   Rd2Addr/Rd2Data, Busy2     : read port 2 and its busy flag
//   LD_CC, NZP                 : load / view condition codes (from WrData)
//   LD_BEN, CondIR, BEN        : load / view registered branch enable
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic             Rsv,
  input  logic [AW-1:0]    RsvAddr,
  input  logic [AW-1:0]    Rd1Addr,
  input  logic [AW-1:0]    Rd2Addr,
  output logic [WIDTH-1:0] Rd1Data,
  output logic [WIDTH-1:0] Rd2Data,
  output logic             Busy1,
  output logic             Busy2,
  input  logic             LD_CC,
  output logic [2:0]       NZP,
  input  logic             LD_BEN,
  input  logic [2:0]       CondIR,
  output logic             BEN
);

  localparam logic BYP_EN = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             byp1, byp2;

  // Clear first, then set: a reservation landing on the register being
  // written back this cycle wins and leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (WrEn) busy_d[WrAddr]  = 1'b0;
    if (Rsv)  busy_d[RsvAddr] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (WrEn) regs_q[WrAddr] <= WrData;
      busy_q <= busy_d;
    end
  end

  assign byp1 = BYP_EN && WrEn && (Rd1Addr == WrAddr);
  assign byp2 = BYP_EN && WrEn && (Rd2Addr == WrAddr);

  assign Rd1Data = byp1 ? WrData : regs_q[Rd1Addr];
  assign Rd2Data = byp2 ? WrData : regs_q[Rd2Addr];

  // A forwarded operand is available now, so it is not reported busy.
  assign Busy1 = busy_q[Rd1Addr] & ~byp1;
  assign Busy2 = busy_q[Rd2Addr] & ~byp2;

  cc_unit #(.WIDTH(WIDTH)) u_cc (
    .Clk    (Clk),
    .Reset  (Reset),
    .LD_CC  (LD_CC),
    .LD_BEN (LD_BEN),
    .CondIR (CondIR),
    .Data   (WrData),
    .NZP    (NZP),
    .BEN    (BEN)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Three instances: bypassing default
// (dut), non-bypassing (dut_nb, same inputs) and a 32-bit/16-register
// variant (dut_w). Inputs change on the falling edge; outputs are sampled
// 1 ns later, i.e. well away from the rising edge.
module tb_regfile_scoreboard;

  localparam int W = 32;

  logic        Clk;
  logic        Reset;
  logic        WrEn, Rsv, LD_CC, LD_BEN;
  logic [2:0]  WrAddr, RsvAddr, Rd1Addr, Rd2Addr, CondIR;
  logic [15:0] WrData;

  logic [15:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy1, busy2, busy1_nb, busy2_nb, ben, ben_nb;
  logic [2:0]  nzp, nzp_nb;

  logic        w_wren, w_rsv, w_ldcc, w_ldben;
  logic [3:0]  w_wraddr, w_rsvaddr, w_rd1addr, w_rd2addr;
  logic [31:0] w_wrdata, w_rd1, w_rd2;
  logic [2:0]  w_condir, w_nzp;
  logic        w_busy1, w_busy2, w_ben;

  logic [W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  regfile_scoreboard #(.WIDTH(16), .NREGS(8), .BYPASS(1)) dut (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Rsv(Rsv), .RsvAddr(RsvAddr), .Rd1Addr(Rd1Addr), .Rd2Addr(Rd2Addr),
    .Rd1Data(rd1), .Rd2Data(rd2), .Busy1(busy1), .Busy2(busy2),
    .LD_CC(LD_CC), .NZP(nzp), .LD_BEN(LD_BEN), .CondIR(CondIR), .BEN(ben)
  );

  regfile_scoreboard #(.WIDTH(16), .NREGS(8), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Rsv(Rsv), .RsvAddr(RsvAddr), .Rd1Addr(Rd1Addr), .Rd2Addr(Rd2Addr),
    .Rd1Data(rd1_nb), .Rd2Data(rd2_nb), .Busy1(busy1_nb), .Busy2(busy2_nb),
    .LD_CC(LD_CC), .NZP(nzp_nb), .LD_BEN(LD_BEN), .CondIR(CondIR), .BEN(ben_nb)
  );

  regfile_scoreboard #(.WIDTH(32), .NREGS(16), .BYPASS(1)) dut_w (
    .Clk(Clk), .Reset(Reset), .WrEn(w_wren), .WrAddr(w_wraddr), .WrData(w_wrdata),
    .Rsv(w_rsv), .RsvAddr(w_rsvaddr), .Rd1Addr(w_rd1addr), .Rd2Addr(w_rd2addr),
    .Rd1Data(w_rd1), .Rd2Data(w_rd2), .Busy1(w_busy1), .Busy2(w_busy2),
    .LD_CC(w_ldcc), .NZP(w_nzp), .LD_BEN(w_ldben), .CondIR(w_condir), .BEN(w_ben)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker / scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_q(input string tag, input logic [W-1:0] got);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " (queue empty)"}, got, ~got);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    WrEn = 0; WrAddr = 0; WrData = 0; Rsv = 0; RsvAddr = 0;
    Rd1Addr = 0; Rd2Addr = 0; LD_CC = 0; LD_BEN = 0; CondIR = 0;
    w_wren = 0; w_wraddr = 0; w_wrdata = 0; w_rsv = 0; w_rsvaddr = 0;
    w_rd1addr = 0; w_rd2addr = 0; w_ldcc = 0; w_ldben = 0; w_condir = 0;
  endtask

  // Cross one rising edge and return at the next falling edge (+1 sample).
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic load_cc(input logic [15:0] d);
    WrData = d; LD_CC = 1;
    step();
    LD_CC = 0;
  endtask

  task automatic load_ben(input logic [2:0] m);
    CondIR = m; LD_BEN = 1;
    step();
    LD_BEN = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    Reset = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1;
    #1;

    // Reset state: every register reads 0 on both ports, nothing busy.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('0);
      exp_q.push_back('0);
    end
    for (int i = 0; i < 8; i++) begin
      Rd1Addr = 3'(i); Rd2Addr = 3'(7 - i);
      #1;
      check_q("reset rd1", W'(rd1));
      check_q("reset rd2", W'(rd2));
      check("reset busy1", W'(busy1), 0);
      check("reset busy2", W'(busy2), 0);
    end
    check("reset nzp", W'(nzp), 32'h2);
    check("reset ben", W'(ben), 0);

    // Write R3 with same-cycle read: bypassed vs stored value.
    @(negedge Clk);
    WrEn = 1; WrAddr = 3; WrData = 16'hBEEF; Rd1Addr = 3;
    #1;
    check("bypass rd1", W'(rd1), 32'hBEEF);
    check("nobypass rd1 same cycle", W'(rd1_nb), 32'h0);
    step();
    WrEn = 0;
    #1;
    check("rd1 after write", W'(rd1), 32'hBEEF);
    check("nb rd1 after write", W'(rd1_nb), 32'hBEEF);

    // Scoreboard: reserve R5, then write it back.
    Rsv = 1; RsvAddr = 5; Rd2Addr = 5;
    #1;
    check("busy2 before reserve edge", W'(busy2), 0);
    step();
    Rsv = 0;
    #1;
    check("busy2 reserved", W'(busy2), 1);
    check("nb busy2 reserved", W'(busy2_nb), 1);
    WrEn = 1; WrAddr = 5; WrData = 16'h0042;
    #1;
    check("busy2 bypassed writeback", W'(busy2), 0);
    check("nb busy2 during writeback", W'(busy2_nb), 1);
    check("rd2 bypassed writeback", W'(rd2), 32'h42);
    step();
    WrEn = 0;
    #1;
    check("busy2 cleared", W'(busy2), 0);
    check("nb busy2 cleared", W'(busy2_nb), 0);
    check("rd2 stored", W'(rd2_nb), 32'h42);
    // Double reservation still cleared by a single writeback.
    Rsv = 1; RsvAddr = 2; Rd1Addr = 2;
    step();
    step();
    Rsv = 0;
    #1;
    check("busy1 double reserve", W'(busy1), 1);
    WrEn = 1; WrAddr = 2; WrData = 16'h1111;
    step();
    WrEn = 0;
    #1;
    check("busy1 single clear", W'(busy1), 0);
    // Rsv and WrEn to the same register: reservation wins.
    Rsv = 1; RsvAddr = 5; WrEn = 1; WrAddr = 5; WrData = 16'h0077;
    step();
    Rsv = 0; WrEn = 0;
    #1;
    check("busy2 rsv wins", W'(busy2), 1);
    check("nb busy2 rsv wins", W'(busy2_nb), 1);
    check("rd2 rsv+write data", W'(rd2), 32'h77);

    // Condition codes (hold when LD_CC=0).
    load_cc(16'h8000);
    check("nzp neg", W'(nzp), 32'h4);
    load_cc(16'h0000);
    check("nzp zero", W'(nzp), 32'h2);
    load_cc(16'h7FFF);
    check("nzp pos", W'(nzp), 32'h1);
    WrData = 16'h8000;
    step();
    check("nzp hold", W'(nzp), 32'h1);

    // Branch enable from NZP=001.
    load_ben(3'b001);
    check("ben p match", W'(ben), 1);
    load_ben(3'b110);
    check("ben no match", W'(ben), 0);
    CondIR = 3'b001;
    step();
    check("ben hold", W'(ben), 0);
    WrData = 16'h0000; LD_CC = 1; CondIR = 3'b010; LD_BEN = 1;
    step();
    LD_CC = 0; LD_BEN = 0;
    check("ben sees old nzp", W'(ben), 0);
    check("nzp after coincident load", W'(nzp), 32'h2);
    load_ben(3'b010);
    check("ben z match", W'(ben), 1);

    // Mid-operation reset with everything asserted.
    Reset = 0; WrEn = 1; WrAddr = 1; WrData = 16'h1234;
    Rsv = 1; RsvAddr = 6; LD_CC = 1; LD_BEN = 1; CondIR = 3'b111;
    step();
    Reset = 1; idle_inputs();
    Rd1Addr = 3; Rd2Addr = 5;
    #1;
    check("reset2 nzp", W'(nzp), 32'h2);
    check("reset2 ben", W'(ben), 0);
    check("reset2 rd1 R3", W'(rd1), 0);
    check("reset2 rd2 R5", W'(rd2), 0);
    check("reset2 busy2 R5", W'(busy2), 0);
    Rd1Addr = 1; Rd2Addr = 6;
    #1;
    check("reset2 rd1 R1", W'(rd1), 0);
    check("reset2 busy2 R6", W'(busy2), 0);

    // Wide variant: WIDTH=32, NREGS=16.
    w_wren = 1; w_wraddr = 15; w_wrdata = 32'hFFFF_FFFF; w_ldcc = 1;
    w_rd1addr = 15; w_rd2addr = 14;
    #1;
    exp_q.push_back(32'hFFFF_FFFF);
    check_q("wide bypass rd1", w_rd1);
    step();
    w_wren = 0; w_ldcc = 0;
    #1;
    exp_q.push_back(32'hFFFF_FFFF);
    check_q("wide rd1 R15", w_rd1);
    check("wide rd2 R14", w_rd2, 0);
    check("wide nzp", W'(w_nzp), 32'h4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
